// File: rtl/timer_sequencer.sv
// Egg-timer control FSM: set-value entry, 1 Hz tick prescaler, counter load/decrement
// strobes, expiry alarm with timed auto-return, and display source selection.
module timer_sequencer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter logic [11:0] MAX_TIME   = 12'd3599,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_min,
  input  logic        btn_sec,
  input  logic        btn_start,
  input  logic        btn_cancel,
  input  logic [11:0] cnt_value,
  output logic        cnt_load,
  output logic [11:0] cnt_load_val,
  output logic        cnt_en,
  output logic [11:0] disp_val,
  output logic        running,
  output logic        paused,
  output logic        alarm
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StPause, StAlarm} state_e;

  state_e          state_q;
  logic [11:0]     set_val_q;
  logic [PW-1:0]   presc_q;
  logic [AW-1:0]   alarm_cnt_q;

  logic [12:0]     set_sum;
  logic [11:0]     set_next;
  logic            presc_wrap;
  logic            any_btn;
  logic            alarm_done;

  // Both set buttons together add 61 before saturating.
  always_comb begin
    set_sum = {1'b0, set_val_q} + (btn_min ? 13'd60 : 13'd0) + (btn_sec ? 13'd1 : 13'd0);
    if (set_sum > {1'b0, MAX_TIME}) begin
      set_next = MAX_TIME;
    end else begin
      set_next = set_sum[11:0];
    end
  end

  assign presc_wrap = (presc_q == PW'(TICK_DIV - 1));
  assign alarm_done = (alarm_cnt_q == AW'(ALARM_SECS - 1));
  assign any_btn    = btn_min | btn_sec | btn_start | btn_cancel;

  assign cnt_load_val = set_val_q;
  assign disp_val     = (state_q == StIdle) ? set_val_q : cnt_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      set_val_q   <= '0;
      presc_q     <= '0;
      alarm_cnt_q <= '0;
      cnt_load    <= 1'b0;
      cnt_en      <= 1'b0;
      running     <= 1'b0;
      paused      <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      cnt_load <= 1'b0;
      cnt_en   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (btn_min || btn_sec) begin
            set_val_q <= set_next;
          end
          if (btn_start && (set_val_q != '0)) begin
            state_q     <= StLoad;
            cnt_load    <= 1'b1;
            presc_q     <= '0;
            alarm_cnt_q <= '0;
          end
        end

        StLoad: begin
          if (btn_cancel) begin
            state_q <= StIdle;
          end else begin
            state_q <= StRun;
            running <= 1'b1;
          end
        end

        StRun: begin
          if (btn_cancel) begin
            state_q <= StIdle;
            running <= 1'b0;
          end else if (cnt_value == '0) begin
            // Expiry outranks a same-cycle pause request.
            state_q     <= StAlarm;
            running     <= 1'b0;
            alarm       <= 1'b1;
            presc_q     <= '0;
            alarm_cnt_q <= '0;
          end else if (btn_start) begin
            // Prescaler is left untouched so the partial second survives the pause.
            state_q <= StPause;
            running <= 1'b0;
            paused  <= 1'b1;
          end else begin
            presc_q <= presc_wrap ? '0 : presc_q + PW'(1);
            cnt_en  <= presc_wrap;
          end
        end

        StPause: begin
          if (btn_cancel) begin
            state_q <= StIdle;
            paused  <= 1'b0;
          end else if (btn_start) begin
            state_q <= StRun;
            paused  <= 1'b0;
            running <= 1'b1;
          end
        end

        StAlarm: begin
          if (any_btn) begin
            state_q <= StIdle;
            alarm   <= 1'b0;
          end else if (presc_wrap) begin
            presc_q <= '0;
            if (alarm_done) begin
              state_q <= StIdle;
              alarm   <= 1'b0;
            end else begin
              alarm_cnt_q <= alarm_cnt_q + AW'(1);
            end
          end else begin
            presc_q <= presc_q + PW'(1);
          end
        end

        default: begin
          state_q <= StIdle;
          running <= 1'b0;
          paused  <= 1'b0;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule
